// File: rtl/sr_drv_pkg.sv
// Shared types, constants and sizing helpers for the pushbutton-to-SR-latch driver.
package sr_drv_pkg;

    // Sequencer states: idle, driving s, driving r, and the mandatory gap between pulses.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE_S = 2'd1,
        ST_PULSE_R = 2'd2,
        ST_GAP     = 2'd3
    } drv_state_e;

    // Number of all-zero cycles inserted after every pulse.
    localparam int GAP_CYCLES = 1;

    // Debounce counter width: must be able to hold DEBOUNCE_CYCLES.
    function automatic int dbc_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // Width of a counter that counts 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// One pushbutton front end: 2-flop synchroniser, debounce counter, stable level
// and a one-cycle press (rising edge of stable) event.
module sr_debounce
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    localparam int             CW       = dbc_width(DEBOUNCE_CYCLES);
    // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES,
    // i.e. when the count already sits at DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two-flop synchroniser for the raw asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; flip stable once enough have been seen.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                rise_d   = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state register; the press event is registered alongside stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Turns two bouncing pushbuttons into mutually exclusive, fixed-width set/reset
// pulses for an SR latch, with a one-deep queue for presses that arrive while busy.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int            PMAX       = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int            PW         = cnt_width(PMAX);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);

    // Index 0 is the set button, index 1 the reset button.
    logic [1:0] btn_raw;
    logic [1:0] press_ev;

    assign btn_raw = {reset_btn, set_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            sr_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .btn_i  (btn_raw[gi]),
                .rise_o (press_ev[gi])
            );
        end
    endgenerate

    logic set_ev;
    logic rst_ev;
    logic both_ev;
    logic one_ev;

    assign set_ev  = press_ev[0];
    assign rst_ev  = press_ev[1];
    assign both_ev = set_ev & rst_ev;
    assign one_ev  = set_ev ^ rst_ev;

    drv_state_e    state_q;
    drv_state_e    state_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          pend_valid_q;
    logic          pend_valid_d;
    logic          pend_set_q;
    logic          pend_set_d;
    logic          conflict_d;
    logic          s_q;
    logic          r_q;
    logic          busy_q;
    logic          conflict_q;

    // Next-state logic: sequencing of pulses, gap timing and the pending slot.
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        pend_valid_d = pend_valid_q;
        pend_set_d   = pend_set_q;
        conflict_d   = 1'b0;

        // While a pulse or gap is in progress, the first new press is queued;
        // a simultaneous pair into an empty slot is reported and discarded.
        if ((state_q != ST_IDLE) && !pend_valid_q) begin
            if (both_ev) begin
                conflict_d = 1'b1;
            end else if (one_ev) begin
                pend_valid_d = 1'b1;
                pend_set_d   = set_ev;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    // A press latched during the final gap cycle is served here.
                    state_d      = pend_set_q ? ST_PULSE_S : ST_PULSE_R;
                    pcnt_d       = '0;
                    pend_valid_d = 1'b0;
                end else if (both_ev) begin
                    conflict_d = 1'b1;
                end else if (set_ev) begin
                    state_d = ST_PULSE_S;
                    pcnt_d  = '0;
                end else if (rst_ev) begin
                    state_d = ST_PULSE_R;
                    pcnt_d  = '0;
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (pcnt_q == PULSE_LAST) begin
                    state_d = ST_GAP;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (pcnt_q == GAP_LAST) begin
                    pcnt_d = '0;
                    if (pend_valid_q) begin
                        state_d      = pend_set_q ? ST_PULSE_S : ST_PULSE_R;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pcnt_d  = '0;
            end
        endcase
    end

    // State, counters, pending slot and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_set_q   <= 1'b0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            busy_q       <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            pend_valid_q <= pend_valid_d;
            pend_set_q   <= pend_set_d;
            s_q          <= (state_d == ST_PULSE_S);
            r_q          <= (state_d == ST_PULSE_R);
            busy_q       <= (state_d != ST_IDLE);
            conflict_q   <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2).
// Edge numbering in each scenario starts at 1 = first edge sampling the new inputs.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst;
    logic set_btn;
    logic reset_btn;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    int n_cmp = 0;
    int n_err = 0;

    sr_latch_driver #(
        .DEBOUNCE_CYCLES (4),
        .PULSE_CYCLES    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_btn   (set_btn),
        .reset_btn (reset_btn),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int n, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    function automatic logic inwin(input int n, input int lo, input int hi);
        return (n >= lo) && (n <= hi);
    endfunction

    // One-cycle synchronous reset with buttons released, then confirm idle outputs.
    task automatic do_reset(input string name);
        rst       = 1'b1;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({name, ":rst_s"},        0, s,        1'b0);
        chk({name, ":rst_r"},        0, r,        1'b0);
        chk({name, ":rst_busy"},     0, busy,     1'b0);
        chk({name, ":rst_conflict"}, 0, conflict, 1'b0);
    endtask

    // Drive buttons over windows [on, off) of edges, optionally pulse rst at one edge,
    // and check every output after every edge against hand-computed windows [lo, hi].
    task automatic run_seq(input string name, input int ncyc,
                           input int set_on, input int set_off,
                           input int rb_on,  input int rb_off,
                           input int rst_at,
                           input int s_lo, input int s_hi,
                           input int r_lo, input int r_hi,
                           input int b_lo, input int b_hi,
                           input int c_edge);
        int s_cnt;
        int r_cnt;
        int c_cnt;
        s_cnt = 0;
        r_cnt = 0;
        c_cnt = 0;
        for (int n = 1; n <= ncyc; n++) begin
            set_btn   = (n >= set_on) && (n < set_off);
            reset_btn = (n >= rb_on) && (n < rb_off);
            rst       = (n == rst_at);
            @(posedge clk);
            #1;
            chk({name, ":s"},        n, s,        inwin(n, s_lo, s_hi));
            chk({name, ":r"},        n, r,        inwin(n, r_lo, r_hi));
            chk({name, ":busy"},     n, busy,     inwin(n, b_lo, b_hi));
            chk({name, ":conflict"}, n, conflict, (n == c_edge));
            chk({name, ":s_and_r"},  n, s & r,    1'b0);
            if (s)        s_cnt++;
            if (r)        r_cnt++;
            if (conflict) c_cnt++;
        end
        rst = 1'b0;
        $display("%s: %0d edges, s cycles %0d, r cycles %0d, conflict cycles %0d",
                 name, ncyc, s_cnt, r_cnt, c_cnt);
    endtask

    initial begin
        rst       = 1'b1;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init:s",        0, s,        1'b0);
        chk("init:r",        0, r,        1'b0);
        chk("init:busy",     0, busy,     1'b0);
        chk("init:conflict", 0, conflict, 1'b0);
        rst = 1'b0;

        // Clean press: s after edges 7..8, busy 7..9 (two pulse cycles + gap).
        do_reset("clean");
        run_seq("clean", 30, 1, 21, 0, 0, 0, 7, 8, 1, 0, 7, 9, 0);

        // Glitch of 3 cycles (one short of the debounce length): nothing happens.
        do_reset("glitch");
        run_seq("glitch", 20, 1, 4, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);

        // Both buttons together: conflict after edge 7 only, no pulses.
        do_reset("simul");
        run_seq("simul", 30, 1, 21, 1, 21, 0, 1, 0, 1, 0, 1, 0, 7);

        // Reset press one cycle after set: s 7..8, gap 9, r 10..11, gap 12.
        do_reset("queued");
        run_seq("queued", 30, 1, 21, 2, 22, 0, 7, 8, 10, 11, 7, 12, 0);

        // rst sampled at edge 8 (first s cycle) with reset press about to queue;
        // buttons released at the same time so nothing is re-detected.
        do_reset("rst_mid");
        run_seq("rst_mid", 30, 1, 8, 2, 8, 8, 7, 7, 1, 0, 7, 7, 0);

        // Long hold: one pulse over 50 held cycles, then release for 10 cycles.
        do_reset("long_a");
        run_seq("long_a", 60, 1, 51, 0, 0, 0, 7, 8, 1, 0, 7, 9, 0);
        // Second press without reset: same 7-edge latency.
        run_seq("long_b", 30, 1, 21, 0, 0, 0, 7, 8, 1, 0, 7, 9, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
